scratch_stack: RTL and testbench

Scratch RAM and stack pointer stage directly downstream of the register file. It consumes the register file's X/Y read ports (DX_OUT → DX_IN data, DY_OUT → DY_IN address) and produces read data that feeds back into the register file's write-data mux (LD/POP) or into the PC load path (RET). It executes one memory/stack operation per clock: store, load, push, pop, call, return and stack-pointer write. It keeps an occupancy count so stack overflow and underflow are reported as sticky flags.

---
 rtl/scratch_stack.sv | 85 ++++++++
 tb/tb_scratch_stack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scratch_stack.sv
// scratch_stack: scratch RAM with a pre-decrement stack pointer, one memory/stack op per clock.
// Overflow/underflow are tracked with an occupancy count and reported as sticky flags.
module scratch_stack #(
    parameter int ADR_W  = 8,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op,
    input  logic [7:0]        dx_in,
    input  logic [7:0]        dy_in,
    input  logic [ADR_W-1:0]  imm_adr,
    input  logic              adr_sel,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADR_W-1:0]  sp_out,
    output logic              ovf,
    output logic              unf
);
    localparam int DEPTH = 2 ** ADR_W;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ST   = 3'd1,
        LD   = 3'd2,
        PUSH = 3'd3,
        POP  = 3'd4,
        CALL = 3'd5,
        RET  = 3'd6,
        WSP  = 3'd7
    } op_t;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [ADR_W:0]    cnt;
    logic [ADR_W-1:0]  adr, sp_dec, wa, ra;
    logic [DATA_W-1:0] wd;
    logic              push, pop, we, re, full, empty;

    always_comb begin
        adr    = adr_sel ? imm_adr : ADR_W'(dy_in);
        push   = op == PUSH || op == CALL;
        pop    = op == POP || op == RET;
        sp_dec = sp_out - ADR_W'(1);
        we     = push || op == ST;
        wa     = push ? sp_dec : adr;
        wd     = op == CALL ? pc_in : DATA_W'(dx_in);
        re     = pop || op == LD;
        ra     = pop ? sp_out : adr;
        full   = cnt == (ADR_W + 1)'(DEPTH);
        empty  = cnt == '0;
    end

    // Gated by rst_n so an op in flight when reset asserts never commits.
    always_ff @(posedge clk) begin
        if (rst_n && we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_out     <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            dout_valid <= re;
            if (re) dout <= mem[ra];
            ovf <= (push && full) || (ovf && !clr_err);
            unf <= (pop && empty) || (unf && !clr_err);
            if (push) begin
                sp_out <= sp_dec;
                if (!full) cnt <= cnt + (ADR_W + 1)'(1);
            end else if (pop) begin
                sp_out <= sp_out + ADR_W'(1);
                if (!empty) cnt <= cnt - (ADR_W + 1)'(1);
            end else if (op == WSP) begin
                sp_out <= ADR_W'(dx_in);
                cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_scratch_stack.sv
// tb_scratch_stack: table of directed vectors plus a behavioural scoreboard for scratch_stack.
module tb_scratch_stack;
    localparam logic [2:0] O_NOP = 0, O_ST = 1, O_LD = 2, O_PUSH = 3,
                           O_POP = 4, O_CALL = 5, O_RET = 6, O_WSP = 7;

    logic       clk = 0, rst_n = 0;
    logic [2:0] op = 0;
    logic [7:0] dx = 0, dy = 0, imm = 0;
    logic       sel = 0, clr = 0;
    logic [9:0] pc = 0;
    logic [9:0] dout;
    logic       dout_valid, ovf, unf;
    logic [7:0] sp_out;

    always #5 clk = ~clk;

    scratch_stack dut (
        .clk(clk), .rst_n(rst_n), .op(op), .dx_in(dx), .dy_in(dy), .imm_adr(imm),
        .adr_sel(sel), .pc_in(pc), .clr_err(clr), .dout(dout), .dout_valid(dout_valid),
        .sp_out(sp_out), .ovf(ovf), .unf(unf)
    );

    int tests = 0, fails = 0;

    // reference model
    logic [9:0] m_mem [256];
    logic [7:0] m_sp = 0;
    int         m_cnt = 0;
    logic       m_ovf = 0, m_unf = 0;
    logic [9:0] m_dout = 0;
    logic [9:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] im, input logic s, input logic [9:0] p, input logic c);
        logic [7:0] a;
        logic       os, us;
        a  = s ? im : y;
        os = 0;
        us = 0;
        if (o == O_ST) m_mem[a] = {2'b0, x};
        if (o == O_LD) q.push_back(m_mem[a]);
        if (o == O_PUSH || o == O_CALL) begin
            m_sp = m_sp - 8'd1;
            m_mem[m_sp] = (o == O_CALL) ? p : {2'b0, x};
            if (m_cnt == 256) os = 1; else m_cnt++;
        end
        if (o == O_POP || o == O_RET) begin
            q.push_back(m_mem[m_sp]);
            m_sp = m_sp + 8'd1;
            if (m_cnt == 0) us = 1; else m_cnt--;
        end
        if (o == O_WSP) begin
            m_sp  = x;
            m_cnt = 0;
        end
        m_ovf = os | (m_ovf & ~c);
        m_unf = us | (m_unf & ~c);
    endtask

    task automatic step(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] im, input logic s, input logic [9:0] p, input logic c);
        logic [9:0] e;
        @(negedge clk);
        op = o; dx = x; dy = y; imm = im; sel = s; pc = p; clr = c;
        @(posedge clk);
        model(o, x, y, im, s, p, c);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_dout = e;
            chk("sb_dout_valid", dout_valid, 1);
            chk("sb_dout", dout, e);
        end else begin
            chk("sb_dout_valid", dout_valid, 0);
            chk("sb_dout_hold", dout, m_dout);
        end
        chk("sb_sp", sp_out, m_sp);
        chk("sb_ovf", ovf, m_ovf);
        chk("sb_unf", unf, m_unf);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] dx, dy, imm;
        logic       sel;
        logic [9:0] pc;
        logic       clr;
        logic [7:0] sp;
        logic       dv;
        logic [9:0] dout;
        logic       ovf, unf;
    } vec_t;

    vec_t tbl [18];

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
        //         op      dx     dy     imm    sel pc       clr  sp     dv dout     ovf unf
        tbl[0]  = '{O_PUSH, 8'h5A, 8'h00, 8'h00, 0, 10'h000, 0, 8'hFF, 0, 10'h000, 0, 0};
        tbl[1]  = '{O_POP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h00, 1, 10'h05A, 0, 0};
        tbl[2]  = '{O_NOP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h00, 0, 10'h05A, 0, 0};
        tbl[3]  = '{O_ST,   8'hC3, 8'h00, 8'h10, 1, 10'h000, 0, 8'h00, 0, 10'h05A, 0, 0};
        tbl[4]  = '{O_LD,   8'h00, 8'h10, 8'h00, 0, 10'h000, 0, 8'h00, 1, 10'h0C3, 0, 0};
        tbl[5]  = '{O_CALL, 8'h00, 8'h00, 8'h00, 0, 10'h3FF, 0, 8'hFF, 0, 10'h0C3, 0, 0};
        tbl[6]  = '{O_RET,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h00, 1, 10'h3FF, 0, 0};
        tbl[7]  = '{O_POP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h01, 1, 10'h000, 0, 1};
        tbl[8]  = '{O_NOP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 1, 8'h01, 0, 10'h000, 0, 0};
        tbl[9]  = '{O_POP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 1, 8'h02, 1, 10'h000, 0, 1};
        tbl[10] = '{O_NOP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 1, 8'h02, 0, 10'h000, 0, 0};
        tbl[11] = '{O_PUSH, 8'h22, 8'h00, 8'h00, 0, 10'h000, 0, 8'h01, 0, 10'h000, 0, 0};
        tbl[12] = '{O_POP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h02, 1, 10'h022, 0, 0};
        tbl[13] = '{O_POP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 0, 8'h03, 1, 10'h000, 0, 1};
        tbl[14] = '{O_NOP,  8'h00, 8'h00, 8'h00, 0, 10'h000, 1, 8'h03, 0, 10'h000, 0, 0};
        tbl[15] = '{O_WSP,  8'h80, 8'h00, 8'h00, 0, 10'h000, 0, 8'h80, 0, 10'h000, 0, 0};
        tbl[16] = '{O_PUSH, 8'h11, 8'h00, 8'h00, 0, 10'h000, 0, 8'h7F, 0, 10'h000, 0, 0};
        tbl[17] = '{O_LD,   8'h00, 8'h00, 8'h7F, 1, 10'h000, 0, 8'h7F, 1, 10'h011, 0, 0};

        #2;
        chk("rst_sp", sp_out, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            step(tbl[i].op, tbl[i].dx, tbl[i].dy, tbl[i].imm, tbl[i].sel, tbl[i].pc, tbl[i].clr);
            chk($sformatf("vec%0d_sp", i), sp_out, tbl[i].sp);
            chk($sformatf("vec%0d_dv", i), dout_valid, tbl[i].dv);
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
            chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("vec%0d_unf", i), unf, tbl[i].unf);
        end

        // fill the stack completely, then one more push overwrites the oldest entry
        step(O_WSP, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(O_PUSH, 8'(i), 0, 0, 0, 0, 0);
        chk("full_no_ovf", ovf, 0);
        chk("full_sp", sp_out, 8'h00);
        step(O_PUSH, 8'hAA, 0, 0, 0, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_sp", sp_out, 8'hFF);
        step(O_POP, 0, 0, 0, 0, 0, 0);
        chk("ovf_pop_dout", dout, 10'h0AA);
        step(O_POP, 0, 0, 0, 0, 0, 0);
        chk("ovf_pop2_dout", dout, 10'h0FF);
        step(O_NOP, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr", ovf, 0);

        // reset asserted mid-cycle during a PUSH: outputs clear at once, write is discarded
        step(O_WSP, 8'h41, 0, 0, 0, 0, 0);
        step(O_ST, 8'h77, 0, 8'h40, 1, 0, 0);
        step(O_POP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        op = O_PUSH; dx = 8'h99; sel = 0; clr = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst_sp", sp_out, 0);
        chk("arst_dout", dout, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_unf", unf, 0);
        m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_dout = 0;
        q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_sp", sp_out, 0);
        @(negedge clk);
        op = O_NOP;
        rst_n = 1;
        step(O_LD, 0, 0, 8'h40, 1, 0, 0);
        chk("arst_no_write", dout, 10'h077);
        step(O_POP, 0, 0, 0, 0, 0, 0);
        chk("arst_cnt_zero", unf, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
